// File: rtl/move_arbiter.sv
// Turn-based move controller for the shared tic-tac-toe board register.
// Grants only the player on turn, writes accepted marks, then scores the board.
//
// state  | meaning
// WAIT   | idle, watching req of the port whose turn it is
// CHECK  | latched cell being validated against range and occupancy
// WRITE  | ack pulse out, mark written into the board
// REJECT | nack pulse out, turn kept
// EVAL   | board scored for win / draw, turn handed over otherwise
// OVER   | game finished, only new_game leaves
module move_arbiter #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        req0,
  input  logic [3:0]  cell0,
  output logic        ack0,
  output logic        nack0,
  input  logic        req1,
  input  logic [3:0]  cell1,
  output logic        ack1,
  output logic        nack1,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        draw,
  output logic        busy
);

  typedef enum logic [2:0] {WAIT, CHECK, WRITE, REJECT, EVAL, OVER} state_t;

  state_t     state;
  logic       armed0, armed1;
  logic       port_q;
  logic [3:0] cell_q;
  logic [1:0] cells [9];
  logic [1:0] line_win;
  logic [1:0] mark;
  logic       full;
  logic       target_taken;
  logic       eligible;

  function automatic logic [1:0] tri3(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c);
    return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
  endfunction

  always_comb begin
    full         = 1'b1;
    target_taken = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cells[i] = board[2*i +: 2];
      if (cells[i] == 2'b00) full = 1'b0;
      if (cell_q == 4'(i) && cells[i] != 2'b00) target_taken = 1'b1;
    end
  end

  // Only the last mover can complete a line, so OR-ing the eight lines is safe.
  assign line_win = tri3(cells[0], cells[1], cells[2]) | tri3(cells[3], cells[4], cells[5])
                  | tri3(cells[6], cells[7], cells[8]) | tri3(cells[0], cells[3], cells[6])
                  | tri3(cells[1], cells[4], cells[7]) | tri3(cells[2], cells[5], cells[8])
                  | tri3(cells[0], cells[4], cells[8]) | tri3(cells[2], cells[4], cells[6]);

  assign eligible = turn ? (req1 && armed1) : (req0 && armed0);
  assign mark     = (port_q == FIRST_PLAYER) ? 2'b01 : 2'b10;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state  <= WAIT;
      board  <= '0;
      turn   <= FIRST_PLAYER;
      winner <= 2'b00;
      draw   <= 1'b0;
      busy   <= 1'b0;
      ack0   <= 1'b0;
      nack0  <= 1'b0;
      ack1   <= 1'b0;
      nack1  <= 1'b0;
      armed0 <= 1'b1;
      armed1 <= 1'b1;
      port_q <= 1'b0;
      cell_q <= '0;
    end else begin
      ack0  <= 1'b0;
      nack0 <= 1'b0;
      ack1  <= 1'b0;
      nack1 <= 1'b0;
      if (!req0) armed0 <= 1'b1;
      if (!req1) armed1 <= 1'b1;

      if (new_game) begin
        state  <= WAIT;
        board  <= '0;
        turn   <= FIRST_PLAYER;
        winner <= 2'b00;
        draw   <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          WAIT: if (eligible) begin
            port_q <= turn;
            cell_q <= turn ? cell1 : cell0;
            busy   <= 1'b1;
            state  <= CHECK;
          end
          // Disarming here, at the edge that raises ack/nack, forces the
          // requester to show req low before it can be granted again.
          CHECK: begin
            if (port_q) armed1 <= 1'b0;
            else        armed0 <= 1'b0;
            if (cell_q > 4'd8 || target_taken) begin
              if (port_q) nack1 <= 1'b1;
              else        nack0 <= 1'b1;
              state <= REJECT;
            end else begin
              if (port_q) ack1 <= 1'b1;
              else        ack0 <= 1'b1;
              state <= WRITE;
            end
          end
          WRITE: begin
            for (int i = 0; i < 9; i++)
              if (cell_q == 4'(i)) board[2*i +: 2] <= mark;
            state <= EVAL;
          end
          REJECT: begin
            busy  <= 1'b0;
            state <= WAIT;
          end
          EVAL: begin
            busy <= 1'b0;
            if (line_win != 2'b00) begin
              winner <= line_win;
              state  <= OVER;
            end else if (full) begin
              draw  <= 1'b1;
              state <= OVER;
            end else begin
              turn  <= ~turn;
              state <= WAIT;
            end
          end
          OVER:    state <= OVER;
          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule

// File: doc/move_arbiter.md
# move_arbiter

Turn-based move controller for the shared board-state register of the tic-tac-toe game. It accepts move requests from two requester ports: port 0 is the local player (mouse path, after `ff_synchronizer`) and port 1 is the remote player (UART receive path). It grants only the player whose turn it is, and rejects out-of-range or occupied cells. It writes accepted marks into the board, then evaluates win/draw before handing the turn over. Its outputs feed the board renderer and the UART transmit path.

## Interface
- `FIRST_PLAYER`, default 0: player that moves first after reset or `new_game` (0 = port 0 plays X, 1 = port 1 plays X).
- `pclk`  in  1  system pixel clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `new_game`  in  1  synchronous clear of the game, single-cycle pulse.
- `req0`  in  1  port 0 move request, level, held until `ack0` or `nack0`.
- `cell0`  in  4  port 0 target cell index 0..8, row-major, stable while `req0` is high.
- `ack0` / `nack0`  out  1 each  port 0 accept / reject pulse, one cycle.
- `req1`, `cell1`, `ack1`, `nack1`: same as port 0, for port 1.
- `board`  out  18  cell i at bits [2i+1:2i]: 00 empty, 01 X, 10 O (11 never driven).
- `turn`  out  1  index of the port allowed to move.
- `winner`  out  2  00 none, 01 X, 10 O.
- `draw`  out  1  board full with no winner.
- `busy`  out  1  high in every state except WAIT and OVER.

## Operation
- **FSM states:** WAIT, CHECK, WRITE, REJECT, EVAL, OVER.
- **Reset values:** WAIT, `board`=0, `turn`=`FIRST_PLAYER`, `winner`=00, `draw`=0, all ack/nack=0, `busy`=0. Both ports are armed.
- **Arming:** a port is armed while its req has been sampled low at least once since its last ack or nack. A request from an unarmed port is ignored.
- **Arbitration (WAIT):** only `req[turn]` is considered, and only from an armed port. A request from the other port is neither acked nor nacked; it stays pending and becomes eligible when the turn changes. Simultaneous requests therefore never conflict.
- **WAIT → CHECK:** on an eligible request. The requesting port and its `cell` are latched into internal registers.
- **CHECK → REJECT:** if the latched cell is greater than 8 or that board cell is non-zero.
- **CHECK → WRITE:** otherwise.
- **REJECT:** pulses nack on the latched port, disarms that port, leaves `turn` unchanged, returns to WAIT.
- **WRITE:** pulses ack on the latched port and disarms it. The mark is written into `board` (X if latched port == `FIRST_PLAYER`, else O). Next state EVAL.
- **EVAL:** checks all 8 lines (3 rows, 3 columns, 2 diagonals).
  - A complete line sets `winner` → OVER.
  - Else, if all 9 cells are non-zero, sets `draw` → OVER.
  - Else toggles `turn` → WAIT.
- **OVER:** all requests are ignored (no ack/nack); arming still tracks req levels. Exits only on `new_game`.
- **`new_game`:** overrides every state. Same values as reset, except arming status is retained. Any transaction in flight is dropped with no ack/nack.
- **Outputs:** ack/nack are one-hot across all four signals; at most one is high in any cycle.

## Timing
- All outputs are registered.
- **Accepted move**, with eligible `req` high in WAIT during cycle 0:
  - cycle 1: CHECK.
  - cycle 2: WRITE, `ack` high.
  - cycle 3: new mark visible on `board`; state EVAL.
  - cycle 4: `turn`, `winner` and `draw` updated; state WAIT or OVER.
- **Rejected move:** `nack` is high in cycle 2; WAIT again in cycle 3.
- **Minimum spacing:** a port must present req low in at least one cycle after its ack/nack before it can be granted again. The earliest re-grant after an ack is cycle 4.
- **Asynchronous `rst` mid-transaction:** all state returns to reset values immediately. No partial board write survives.
- **`new_game` in WRITE:** the board clears at the next edge; the ack pulse already asserted in that cycle still completes.

## Test plan
- **Legal move:** reset, `FIRST_PLAYER`=0, `req0`=1, `cell0`=4 → `ack0` in cycle 2, `board`=0x00100 in cycle 3, `turn`=1 in cycle 4.
- **Wrong-turn request:** with `turn`=1, hold `req0`=1 for 20 cycles → no `ack0`/`nack0`, board unchanged. Then assert `req1`, `cell1`=0 → `ack1`, board cell 0 = 10, `turn`=0, then `req0` is granted.
- **Illegal cells:** `cell0`=4 on an occupied cell → `nack0`, `turn` unchanged. `cell0`=9 and `cell0`=15 → `nack0`. After a nack, a held `req0` is not re-granted until it drops low.
- **Win:** X plays 0,1,2 interleaved with O playing 3,4 → `winner`=01 in the cycle after the third X write, state OVER; a further `req1` gets no response.
- **Draw:** X 0,2,3,7,8; O 1,4,5,6 → `draw`=1, `winner`=00, OVER. Then `new_game` → `board`=0, `turn`=`FIRST_PLAYER`, `draw`=0.
- **Reset and clear mid-transaction:** assert `rst` in CHECK → all outputs at reset values immediately, no ack issued. Pulse `new_game` in EVAL → board cleared, no turn toggle, WAIT.
